// File: rtl/sprite_fetch.sv
// sprite_fetch: per-row OAM scanner that feeds visible sprites into the head
// of the sprite_unit chain, lowest OAM index first.
// Optional feature: define SPRITE_OVERFLOW_SCAN_EN to keep scanning past
// MAX_SPRITES and flag sprite_overflow when further visible entries exist.

package sprite_fetch_pkg;

  localparam int unsigned PAT_W = 32;

  typedef struct packed {
    logic [8:0] x;
    logic [1:0] w;
    logic       x_mirror;
    logic [2:0] palette;
    logic       fg_prio;
    logic       bg_prio;
  } sprite_conf_t;

  typedef struct packed {
    logic [PAT_W-1:0] pat;
    sprite_conf_t     conf;
  } sprite_reg_t;

  // OAM word layout, MSB first so y lands in the low byte
  typedef struct packed {
    logic       y_mirror;
    logic       x_mirror;
    logic       bg_prio;
    logic       fg_prio;
    logic [2:0] palette;
    logic [1:0] h;
    logic [1:0] w;
    logic [9:0] tile;
    logic [8:0] x;
    logic [7:0] y;
  } oam_entry_t;

endpackage

module sprite_fetch
  import sprite_fetch_pkg::*;
#(
  parameter int unsigned MAX_SPRITES = 16
) (
  input  logic             clock,
  input  logic             reset_l,
  input  logic             start,
  input  logic             clear,
  input  logic [7:0]       row,
  output logic [5:0]       oam_addr,
  input  logic [37:0]      oam_rddata,
  output logic [14:0]      pat_addr,
  input  logic [PAT_W-1:0] pat_rddata,
  output sprite_reg_t      out,
  output logic             out_valid,
  input  logic             out_ack,
  output logic             busy,
  output logic             done,
  output logic             sprite_overflow
);

  localparam logic [6:0] MAX_CNT  = 7'(MAX_SPRITES);
  localparam logic [5:0] LAST_IDX = 6'd63;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    CHECK,
    FETCH,
    LOAD,
    SEND,
    DONE
  } state_t;

  state_t       state;
  logic [7:0]   row_q;
  logic [5:0]   idx;
  logic [6:0]   count;
  sprite_conf_t conf_q;

  oam_entry_t   oam_e;
  logic [7:0]   dy;
  logic [4:0]   span;
  logic [4:0]   prow;
  logic         visible;
  logic         last_idx;
  logic         last_sprite;

`ifdef SPRITE_OVERFLOW_SCAN_EN
  logic         ovf_scan;
`else
  assign sprite_overflow = 1'b0;
`endif

  assign oam_e = oam_entry_t'(oam_rddata);

  // Visibility test and pattern row selection for the entry being checked
  always_comb begin
    dy          = row_q - oam_e.y;
    span        = {oam_e.h, 3'b000};
    visible     = (oam_e.w != 2'd0) && (oam_e.h != 2'd0) && (dy < {3'b000, span});
    // 5-bit arithmetic wraps identically to the full subtraction truncated to 5 bits
    prow        = oam_e.y_mirror ? (span - 5'd1 - dy[4:0]) : dy[4:0];
    last_idx    = (idx == LAST_IDX);
    last_sprite = ((count + 7'd1) == MAX_CNT);
  end

  // Fetch sequencer with registered outputs
  always_ff @(posedge clock or negedge reset_l) begin
    if (!reset_l) begin
      state     <= IDLE;
      row_q     <= '0;
      idx       <= '0;
      count     <= '0;
      conf_q    <= '0;
      oam_addr  <= '0;
      pat_addr  <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SPRITE_OVERFLOW_SCAN_EN
      ovf_scan        <= 1'b0;
      sprite_overflow <= 1'b0;
`endif
    end else if (clear) begin
      state     <= IDLE;
      idx       <= '0;
      count     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SPRITE_OVERFLOW_SCAN_EN
      ovf_scan        <= 1'b0;
      sprite_overflow <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            row_q    <= row;
            idx      <= '0;
            count    <= '0;
            oam_addr <= '0;
            busy     <= 1'b1;
            state    <= SCAN;
`ifdef SPRITE_OVERFLOW_SCAN_EN
            ovf_scan        <= 1'b0;
            sprite_overflow <= 1'b0;
`endif
          end
        end

        SCAN: begin
          state <= CHECK;
        end

        CHECK: begin
`ifdef SPRITE_OVERFLOW_SCAN_EN
          // Past the sprite limit only look for further hits, never send
          if (ovf_scan) begin
            if (visible) begin
              sprite_overflow <= 1'b1;
            end
            if (last_idx) begin
              done  <= 1'b1;
              state <= DONE;
            end else begin
              idx      <= idx + 6'd1;
              oam_addr <= idx + 6'd1;
              state    <= SCAN;
            end
          end else
`endif
          if (visible) begin
            pat_addr <= {oam_e.tile, prow};
            conf_q   <= '{x:        oam_e.x,
                          w:        oam_e.w,
                          x_mirror: oam_e.x_mirror,
                          palette:  oam_e.palette,
                          fg_prio:  oam_e.fg_prio,
                          bg_prio:  oam_e.bg_prio};
            state    <= FETCH;
          end else if (last_idx) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx      <= idx + 6'd1;
            oam_addr <= idx + 6'd1;
            state    <= SCAN;
          end
        end

        FETCH: begin
          state <= LOAD;
        end

        LOAD: begin
          out.pat   <= pat_rddata;
          out.conf  <= conf_q;
          out_valid <= 1'b1;
          state     <= SEND;
        end

        SEND: begin
          if (out_valid && out_ack) begin
            out_valid <= 1'b0;
            count     <= count + 7'd1;
            if (last_idx) begin
              done  <= 1'b1;
              state <= DONE;
            end else if (last_sprite) begin
`ifdef SPRITE_OVERFLOW_SCAN_EN
              ovf_scan <= 1'b1;
              idx      <= idx + 6'd1;
              oam_addr <= idx + 6'd1;
              state    <= SCAN;
`else
              done  <= 1'b1;
              state <= DONE;
`endif
            end else begin
              idx      <= idx + 6'd1;
              oam_addr <= idx + 6'd1;
              state    <= SCAN;
            end
          end
        end

        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_fetch.sv
// tb_sprite_fetch: scoreboard bench for sprite_fetch. A row-level model
// predicts the transfer sequence; a negedge monitor checks every handshake.

module tb_sprite_fetch;
  import sprite_fetch_pkg::*;

  localparam int MAXS = 16;

  logic        clock;
  logic        reset_l;
  logic        start;
  logic        clear;
  logic [7:0]  row;
  logic [5:0]  oam_addr;
  logic [37:0] oam_rddata;
  logic [14:0] pat_addr;
  logic [31:0] pat_rddata;
  sprite_reg_t out;
  logic        out_valid;
  logic        out_ack;
  logic        busy;
  logic        done;
  logic        sprite_overflow;

  sprite_fetch #(.MAX_SPRITES(MAXS)) dut (
    .clock          (clock),
    .reset_l        (reset_l),
    .start          (start),
    .clear          (clear),
    .row            (row),
    .oam_addr       (oam_addr),
    .oam_rddata     (oam_rddata),
    .pat_addr       (pat_addr),
    .pat_rddata     (pat_rddata),
    .out            (out),
    .out_valid      (out_valid),
    .out_ack        (out_ack),
    .busy           (busy),
    .done           (done),
    .sprite_overflow(sprite_overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // OAM contents as plain integer fields
  int oy[64], ox[64], ot[64], ow[64], oh[64], opal[64], ofg[64], obg[64], oxm[64], oym[64];

  int n_checks = 0;
  int n_fail   = 0;

  longint exp_q[$];
  logic   exp_ovf = 1'b0;
  bit     mon_en  = 1'b0;
  bit     held    = 1'b0;
  logic [63:0] held_out;
  int     ack_mode = 2;
  int     vcnt = 0;

  function automatic longint pack_oam(input int i);
    return longint'(oy[i]) + (longint'(ox[i]) << 8) + (longint'(ot[i]) << 17) +
           (longint'(ow[i]) << 27) + (longint'(oh[i]) << 29) + (longint'(opal[i]) << 31) +
           (longint'(ofg[i]) << 34) + (longint'(obg[i]) << 35) +
           (longint'(oxm[i]) << 36) + (longint'(oym[i]) << 37);
  endfunction

  function automatic longint pat_fn(input int a);
    return ((longint'(a) << 17) | (longint'(a ^ 32'h7fff) << 2) | 1) & 64'hffff_ffff;
  endfunction

  // Synchronous OAM and pattern memories, one cycle read latency
  always @(posedge clock) begin
    oam_rddata <= 38'(pack_oam(int'(oam_addr)));
    pat_rddata <= 32'(pat_fn(int'(pat_addr)));
  end

  // Chain-head acknowledge: random, delayed by five valid cycles, or never
  always @(posedge clock) begin
    #1;
    case (ack_mode)
      0: out_ack = 1'($urandom_range(0, 1));
      1: begin
        if (out_valid) vcnt = vcnt + 1;
        else vcnt = 0;
        out_ack = (vcnt > 5);
      end
      default: out_ack = 1'b0;
    endcase
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard monitor
  always @(negedge clock) begin
    if (mon_en) begin
      if (out_valid) begin
        if (held) chk("hold_stable", 64'(out), held_out);
        if (out_ack) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_transfer: got %0h expected none", 64'(out));
          end else begin
            chk("transfer", 64'(out), 64'(exp_q.pop_front()));
          end
          held = 1'b0;
        end else begin
          held     = 1'b1;
          held_out = 64'(out);
        end
      end else begin
        if (held) chk("valid_hold", 64'(out_valid), 64'd1);
        held = 1'b0;
      end
      if (done) begin
        chk("pending_at_done", 64'(exp_q.size()), 64'd0);
        chk("overflow_at_done", 64'(sprite_overflow), 64'(exp_ovf));
      end
    end
  end

  task automatic clear_oam();
    for (int i = 0; i < 64; i++) begin
      oy[i] = 0; ox[i] = 0; ot[i] = 0; ow[i] = 0; oh[i] = 0;
      opal[i] = 0; ofg[i] = 0; obg[i] = 0; oxm[i] = 0; oym[i] = 0;
    end
  endtask

  task automatic set_spr(input int i, input int y, input int x, input int tile, input int w,
                         input int h, input int ym);
    oy[i] = y; ox[i] = x; ot[i] = tile; ow[i] = w; oh[i] = h; oym[i] = ym;
    opal[i] = $urandom_range(0, 7); ofg[i] = $urandom_range(0, 1);
    obg[i] = $urandom_range(0, 1); oxm[i] = $urandom_range(0, 1);
  endtask

  task automatic rand_oam(input int r);
    for (int i = 0; i < 64; i++) begin
      if ($urandom_range(0, 2) == 0) oy[i] = $urandom_range(0, 255);
      else oy[i] = (r - $urandom_range(0, 31) + 256) % 256;
      ox[i] = $urandom_range(0, 511); ot[i] = $urandom_range(0, 1023);
      ow[i] = $urandom_range(0, 3); oh[i] = $urandom_range(0, 3);
      opal[i] = $urandom_range(0, 7); ofg[i] = $urandom_range(0, 1);
      obg[i] = $urandom_range(0, 1); oxm[i] = $urandom_range(0, 1);
      oym[i] = $urandom_range(0, 1);
    end
  endtask

  // Row model: walk OAM in index order, keep the first MAXS hits
  task automatic build_expect(input int r);
    int n = 0;
    exp_q.delete();
    for (int i = 0; i < 64; i++) begin
      int dy, hh, prow;
      longint conf;
      dy = (r - oy[i] + 256) % 256;
      hh = oh[i] * 8;
      if (ow[i] != 0 && oh[i] != 0 && dy < hh) begin
        n++;
        if (n <= MAXS) begin
          prow = (oym[i] != 0) ? (hh - 1 - dy) : dy;
          prow = prow % 32;
          conf = (longint'(ox[i]) << 8) | (longint'(ow[i]) << 6) | (longint'(oxm[i]) << 5) |
                 (longint'(opal[i]) << 2) | (longint'(ofg[i]) << 1) | longint'(obg[i]);
          exp_q.push_back((pat_fn(ot[i] * 32 + prow) << 17) | conf);
        end
      end
    end
`ifdef SPRITE_OVERFLOW_SCAN_EN
    exp_ovf = (n > MAXS);
`else
    exp_ovf = 1'b0;
`endif
  endtask

  task automatic run_row(input int r);
    bit got = 0;
    build_expect(r);
    held   = 1'b0;
    mon_en = 1'b1;
    @(negedge clock);
    start = 1'b1; row = 8'(r);
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    // start while busy must be ignored
    start = 1'b1; row = ~8'(r);
    @(negedge clock);
    start = 1'b0; row = 8'(r);
    for (int c = 0; c < 4000; c++) begin
      if (done) begin got = 1; break; end
      @(negedge clock);
    end
    chk("done_seen", 64'(got), 64'd1);
    if (!got) exp_q.delete();
    @(negedge clock);
    chk("done_width", 64'(done), 64'd0);
    chk("idle_after_done", 64'(busy), 64'd0);
    mon_en = 1'b0;
  endtask

  task automatic watch_no_done(input string name);
    int dn = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (done) dn++;
    end
    chk(name, 64'(dn), 64'd0);
    chk({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit got;
    reset_l = 1'b0; start = 1'b0; clear = 1'b0; row = '0; out_ack = 1'b0;
    clear_oam();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out", 64'(out), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_oam_addr", 64'(oam_addr), 64'd0);
    chk("rst_pat_addr", 64'(pat_addr), 64'd0);
    chk("rst_overflow", 64'(sprite_overflow), 64'd0);
    repeat (3) @(negedge clock);
    reset_l = 1'b1;
    ack_mode = 0;

    // single visible entry at index 5, expected prow 2
    clear_oam();
    set_spr(5, 10, 20, 10'h155, 1, 1, 0);
    run_row(12);

    // y-mirrored tall sprite: prow = 16-1-3 = 12
    clear_oam();
    set_spr(3, 0, 100, 10'h0aa, 2, 2, 1);
    run_row(3);

    // wrap-around in dy
    clear_oam();
    set_spr(7, 250, 300, 10'h3ff, 2, 1, 0);
    run_row(2);
    run_row(1);

    // acknowledge withheld for five valid cycles
    ack_mode = 1;
    clear_oam();
    set_spr(0, 40, 1, 5, 1, 1, 0);
    set_spr(9, 38, 2, 6, 3, 3, 1);
    run_row(44);
    ack_mode = 0;

    // 20 visible entries, only first MAXS sent
    clear_oam();
    for (int i = 0; i < 20; i++) set_spr(i, 60, i * 7, i + 1, 1 + i % 3, 1 + i % 3, i % 2);
    run_row(62);

    // exactly MAXS visible ending at index 63
    clear_oam();
    for (int i = 48; i < 64; i++) set_spr(i, 200, i, i * 3, 3, 1, 0);
    run_row(207);

    // randomized rows
    for (int k = 0; k < 10; k++) begin
      int r;
      r = $urandom_range(0, 255);
      rand_oam(r);
      run_row(r);
    end

    // clear wins over start in the same cycle
    @(negedge clock);
    clear = 1'b1; start = 1'b1; row = 8'd5;
    @(negedge clock);
    clear = 1'b0; start = 1'b0;
    chk("clear_beats_start", 64'(busy), 64'd0);

    // clear while holding a record in SEND
    ack_mode = 2;
    clear_oam();
    set_spr(0, 10, 33, 77, 1, 1, 0);
    start = 1'b1; row = 8'd11;
    @(negedge clock);
    start = 1'b0;
    got = 0;
    for (int c = 0; c < 100; c++) begin
      if (out_valid) begin got = 1; break; end
      @(negedge clock);
    end
    chk("reach_send", 64'(got), 64'd1);
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    chk("clear_out_valid", 64'(out_valid), 64'd0);
    chk("clear_out", 64'(out), 64'd0);
    chk("clear_busy", 64'(busy), 64'd0);
    chk("clear_overflow", 64'(sprite_overflow), 64'd0);
    watch_no_done("clear_no_done");

    // asynchronous reset while in FETCH
    @(negedge clock);
    start = 1'b1; row = 8'd11;
    @(negedge clock);
    start = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #2;
    reset_l = 1'b0;
    #1;
    chk("arst_out_valid", 64'(out_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_done", 64'(done), 64'd0);
    chk("arst_oam_addr", 64'(oam_addr), 64'd0);
    chk("arst_pat_addr", 64'(pat_addr), 64'd0);
    @(negedge clock);
    reset_l = 1'b1;
    watch_no_done("arst_no_done");

    // normal operation resumes afterwards
    ack_mode = 0;
    run_row(11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sprite_fetch.md
SPRITE_FETCH -- requirements
Module: sprite_fetch

Interface
REQ-001 Parameter MAX_SPRITES, default 16, is the maximum number of sprites sent into the sprite chain per row (1..64).
REQ-002 clock  in  1  system clock.
REQ-003 reset_l  in  1  asynchronous active-low reset.
REQ-004 start  in  1  single-cycle pulse at hblank; begins a fetch for the row on `row`.
REQ-005 clear  in  1  synchronous abort; also drives the chain clear.
REQ-006 row  in  8  screen row to fetch, latched on accepted start.
REQ-007 oam_addr  out  6  OAM entry index; synchronous read with 1-cycle latency.
REQ-008 oam_rddata  in  38  OAM entry, fields from the LSB: y[8], x[9], tile[10], w[2], h[2], palette[3], fg_prio, bg_prio, x_mirror, y_mirror.
REQ-009 pat_addr  out  15  pattern row address {tile, prow[4:0]}; synchronous read with 1-cycle latency.
REQ-010 pat_rddata  in  sprite pat width  one sprite row of pixels.
REQ-011 out  out  sprite_reg_t  sprite record to the head of the sprite_unit chain.
REQ-012 out_valid  out  1  the record on `out` is valid.
REQ-013 out_ack  in  1  the chain head accepts the record; combinational from the chain.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 done  out  1  one-cycle pulse when the row fetch completes.
REQ-016 sprite_overflow  out  1  more than MAX_SPRITES sprites hit the row (see Configuration).

Function
REQ-017 The FSM SHALL have the states IDLE, SCAN, CHECK, FETCH, LOAD, SEND and DONE.
REQ-018 IDLE: on start, the block SHALL latch row, set idx=0 and count=0, and go to SCAN. While not in IDLE, start SHALL be ignored.
REQ-019 SCAN: the block SHALL drive oam_addr=idx and then go to CHECK.
REQ-020 CHECK: dy = row - y, 8-bit unsigned with wrap. A sprite SHALL be visible when w!=0, h!=0 and dy < {h,3'b000}.
- Visible: go to FETCH.
- Not visible, idx==63: go to DONE.
- Not visible otherwise: idx+1, then SCAN.
REQ-021 FETCH: the block SHALL drive pat_addr={tile, prow}.
- prow = y_mirror ? ({h,3'b000}-1-dy) : dy, truncated to 5 bits.
- Latch the OAM fields, then go to LOAD.
REQ-022 LOAD: the block SHALL register out.pat=pat_rddata and out.conf={x, w, x_mirror, palette, fg_prio, bg_prio}, set out_valid=1, and go to SEND.
REQ-023 SEND: out and out_valid SHALL hold stable until a cycle in which out_valid and out_ack are both high. In that cycle:
- out_valid falls next cycle and count increments.
- count==MAX_SPRITES or idx==63: go to DONE.
- Otherwise: idx+1, then SCAN.
REQ-024 DONE: done SHALL be 1 for exactly one cycle, then the FSM goes to IDLE.
REQ-025 Sprites SHALL be sent in ascending OAM index order, so the lowest index ends up farthest along the chain.
REQ-026 clear in any state SHALL force, next cycle: IDLE, out_valid=0, out=0, and no done pulse. clear has priority over start in the same cycle.
REQ-027 out_ack while out_valid=0 SHALL be ignored.
REQ-028 Once count reaches MAX_SPRITES, the remaining OAM entries SHALL NOT be sent.

Reset
REQ-029 reset_l low SHALL asynchronously force:
- the FSM to IDLE;
- out=0, out_valid=0;
- oam_addr=0, pat_addr=0;
- busy=0, done=0, sprite_overflow=0;
- idx=0, count=0.
REQ-030 Reset mid-row SHALL discard the fetch in progress. No start is implied on reset release.

Configuration
REQ-031 Macro SPRITE_OVERFLOW_SCAN_EN.
- Defined: once count==MAX_SPRITES, the block SHALL keep scanning (SCAN/CHECK only) to idx==63. sprite_overflow SHALL be set if any further entry is visible; it is cleared on the next accepted start, on clear and on reset.
- Undefined: the block SHALL go straight to DONE at MAX_SPRITES, and sprite_overflow SHALL be tied to 0.

Verification
REQ-032 Only OAM[5] is visible (y=10, x=20, w=1, h=1, row=12) -> oam_addr=5 scan, pat_addr={tile,5'd2}, one transfer with conf.x=20, then done.
REQ-033 OAM[3] has y_mirror=1, h=2, y=0, row=3 -> prow=12.
REQ-034 y=250, h=1, row=2 -> dy=8 gives not visible; with row=1 -> dy=7 gives visible (wrap-around).
REQ-035 out_ack held low for 5 cycles in SEND -> out and out_valid stable for 5 cycles; transfer on the first ack.
REQ-036 20 visible sprites, MAX_SPRITES=16 -> exactly 16 transfers at indices 0..15. sprite_overflow=1 only with SPRITE_OVERFLOW_SCAN_EN.
REQ-037 clear pulsed in SEND, and reset_l pulsed in FETCH -> out_valid=0 next cycle or immediately, FSM in IDLE, no done pulse.
